decode_stage: RTL and testbench

Pipelined instruction-decode stage for the mini MIPS core, sitting between fetch (IF) and execute (EX). It registers a fully decoded control packet per instruction behind a valid/ready handshake. It also detects load-use hazards against the instruction currently in EX, honours a branch/jump flush, and counts stall cycles. This is the parametrised successor to the combinational decoder: same opcode/ALU encodings, plus corrected branch opcodes, `jr` handling, illegal-instruction flagging, and pipeline control.

---
 rtl/cpu_pkg.sv | 98 +++++++++
 rtl/decode_ctrl.sv | 109 ++++++++++
 rtl/decode_stage.sv | 118 +++++++++++
 tb/tb_decode_stage.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the mini MIPS core: opcodes, functs, ALU codes,
// branch types and the decoded control packet.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_BLT   = 6'h14;
    localparam logic [5:0] OP_BGE   = 6'h15;
    localparam logic [5:0] OP_BLTU  = 6'h16;
    localparam logic [5:0] OP_BGTU  = 6'h17;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_SUBU = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLL  = 5'd9;
    localparam logic [4:0] ALU_SRL  = 5'd10;
    localparam logic [4:0] ALU_SRA  = 5'd11;
    localparam logic [4:0] ALU_LUI  = 5'd12;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_EQ   = 4'd1;
    localparam logic [3:0] BR_NE   = 4'd2;
    localparam logic [3:0] BR_LTE  = 4'd3;
    localparam logic [3:0] BR_GT   = 4'd4;
    localparam logic [3:0] BR_LT   = 4'd5;
    localparam logic [3:0] BR_GTE  = 4'd6;
    localparam logic [3:0] BR_LTU  = 4'd7;
    localparam logic [3:0] BR_GTU  = 4'd8;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic [4:0] shamt;
        logic [4:0] alu_ctrl;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [3:0] branch_type;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       illegal;
    } ctrl_pkt_t;

    // BR_NONE doubles as "not a branch opcode".
    function automatic logic [3:0] branch_of(input logic [5:0] op);
        case (op)
            OP_BEQ:  return BR_EQ;
            OP_BNE:  return BR_NE;
            OP_BLEZ: return BR_LTE;
            OP_BGTZ: return BR_GT;
            OP_BLT:  return BR_LT;
            OP_BGE:  return BR_GTE;
            OP_BLTU: return BR_LTU;
            OP_BGTU: return BR_GTU;
            default: return BR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Pure combinational decoder: instruction word to control packet and
// extended immediate.
module decode_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    output ctrl_pkt_t         pkt,
    output logic [DATA_W-1:0] imm,
    output logic              uses_rt
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm16;
    logic        zext;
    logic [3:0]  br;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign imm16 = instr[15:0];
    assign br    = branch_of(op);
    assign zext  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    assign imm   = zext ? {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};

    always_comb begin
        pkt       = '0;
        pkt.rs    = instr[25:21];
        pkt.rt    = instr[20:16];
        pkt.shamt = instr[10:6];
        uses_rt   = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rt       = 1'b1;
                pkt.dest      = instr[15:11];
                pkt.reg_write = 1'b1;
                case (fn)
                    FN_ADD:  pkt.alu_ctrl = ALU_ADD;
                    FN_ADDU: pkt.alu_ctrl = ALU_ADDU;
                    FN_SUB:  pkt.alu_ctrl = ALU_SUB;
                    FN_SUBU: pkt.alu_ctrl = ALU_SUBU;
                    FN_AND:  pkt.alu_ctrl = ALU_AND;
                    FN_OR:   pkt.alu_ctrl = ALU_OR;
                    FN_XOR:  pkt.alu_ctrl = ALU_XOR;
                    FN_SLT:  pkt.alu_ctrl = ALU_SLT;
                    FN_SLL:  pkt.alu_ctrl = ALU_SLL;
                    FN_SRL:  pkt.alu_ctrl = ALU_SRL;
                    FN_SRA:  pkt.alu_ctrl = ALU_SRA;
                    FN_JR: begin
                        pkt.dest      = '0;
                        pkt.reg_write = 1'b0;
                        pkt.jump_reg  = 1'b1;
                    end
                    default: begin
                        pkt.dest      = '0;
                        pkt.reg_write = 1'b0;
                        pkt.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                pkt.alu_src   = 1'b1;
                pkt.dest      = instr[20:16];
                pkt.reg_write = 1'b1;
                case (op)
                    OP_ADDI:  pkt.alu_ctrl = ALU_ADD;
                    OP_ADDIU: pkt.alu_ctrl = ALU_ADDU;
                    OP_SLTI:  pkt.alu_ctrl = ALU_SLT;
                    OP_ANDI:  pkt.alu_ctrl = ALU_AND;
                    OP_ORI:   pkt.alu_ctrl = ALU_OR;
                    OP_XORI:  pkt.alu_ctrl = ALU_XOR;
                    default:  pkt.alu_ctrl = ALU_LUI;
                endcase
            end
            OP_LW: begin
                pkt.alu_ctrl   = ALU_ADD;
                pkt.alu_src    = 1'b1;
                pkt.dest       = instr[20:16];
                pkt.reg_write  = 1'b1;
                pkt.mem_read   = 1'b1;
                pkt.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                pkt.alu_ctrl  = ALU_ADD;
                pkt.alu_src   = 1'b1;
                pkt.mem_write = 1'b1;
            end
            OP_J: pkt.jump = 1'b1;
            OP_JAL: begin
                pkt.jump      = 1'b1;
                pkt.link      = 1'b1;
                pkt.reg_write = 1'b1;
                pkt.dest      = LINK_REG;
            end
            default: begin
                if (br != BR_NONE) begin
                    uses_rt         = 1'b1;
                    pkt.alu_ctrl    = ALU_SUB;
                    pkt.branch_type = br;
                end else begin
                    pkt.illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use hazard bubble,
// flush squash and saturating stall counter.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ALU_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_instr,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic                   flush,
    input  logic                   ex_mem_read,
    input  logic [REG_AW-1:0]      ex_rt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_pc,
    output logic [REG_AW-1:0]      out_rs,
    output logic [REG_AW-1:0]      out_rt,
    output logic [REG_AW-1:0]      out_dest,
    output logic [4:0]             out_shamt,
    output logic [DATA_W-1:0]      out_imm,
    output logic [ALU_W-1:0]       out_alu_ctrl,
    output logic                   out_alu_src,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic [3:0]             out_branch_type,
    output logic                   out_jump,
    output logic                   out_jump_reg,
    output logic                   out_link,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_pkt_t               dec_pkt_p0;
    logic [DATA_W-1:0]       dec_imm_p0;
    logic                    dec_uses_rt_p0;
    logic [REG_AW-1:0]       dec_rs_p0;
    logic [REG_AW-1:0]       dec_rt_p0;
    logic                    hazard;
    logic                    adv;

    ctrl_pkt_t               pkt_p1;
    logic [DATA_W-1:0]       imm_p1;
    logic [DATA_W-1:0]       pc_p1;
    logic                    vld_p1;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;

    // Stage 0: combinational decode and hazard check of the incoming word
    decode_ctrl #(.DATA_W(DATA_W)) u_decode_ctrl (
        .instr   (in_instr),
        .pkt     (dec_pkt_p0),
        .imm     (dec_imm_p0),
        .uses_rt (dec_uses_rt_p0)
    );

    assign dec_rs_p0 = REG_AW'(dec_pkt_p0.rs);
    assign dec_rt_p0 = REG_AW'(dec_pkt_p0.rt);

    assign hazard = in_valid && ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == dec_rs_p0) || (dec_uses_rt_p0 && (ex_rt == dec_rt_p0)));
    assign adv      = !vld_p1 || out_ready;
    assign in_ready = flush || (adv && !hazard);

    // Stage 1: packet register toward EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pkt_p1      <= '0;
            imm_p1      <= '0;
            pc_p1       <= '0;
            stall_cnt_r <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            if (hazard) begin
                vld_p1 <= 1'b0;
                if (stall_cnt_r != '1)
                    stall_cnt_r <= stall_cnt_r + 1'b1;
            end else begin
                vld_p1 <= in_valid;
                if (in_valid) begin
                    pkt_p1 <= dec_pkt_p0;
                    imm_p1 <= dec_imm_p0;
                    pc_p1  <= in_pc;
                end
            end
        end
    end

    assign out_valid       = vld_p1;
    assign out_pc          = pc_p1;
    assign out_rs          = REG_AW'(pkt_p1.rs);
    assign out_rt          = REG_AW'(pkt_p1.rt);
    assign out_dest        = REG_AW'(pkt_p1.dest);
    assign out_shamt       = pkt_p1.shamt;
    assign out_imm         = imm_p1;
    assign out_alu_ctrl    = ALU_W'(pkt_p1.alu_ctrl);
    assign out_alu_src     = pkt_p1.alu_src;
    assign out_reg_write   = pkt_p1.reg_write;
    assign out_mem_read    = pkt_p1.mem_read;
    assign out_mem_write   = pkt_p1.mem_write;
    assign out_mem_to_reg  = pkt_p1.mem_to_reg;
    assign out_branch_type = pkt_p1.branch_type;
    assign out_jump        = pkt_p1.jump;
    assign out_jump_reg    = pkt_p1.jump_reg;
    assign out_link        = pkt_p1.link;
    assign out_illegal     = pkt_p1.illegal;
    assign stall_cnt       = stall_cnt_r;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against
// a cycle-level reference model built from the instruction-set rules.
module tb_decode_stage;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [3:0]  br;
        logic        jump;
        logic        jump_reg;
        logic        link;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs, out_rt, out_dest, out_shamt, out_alu_ctrl;
    logic [31:0] out_imm;
    logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic [3:0]  out_branch_type;
    logic        out_jump, out_jump_reg, out_link, out_illegal;
    logic [1:0]  stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .REG_AW(5), .ALU_W(5), .STALL_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch_type(out_branch_type), .out_jump(out_jump),
        .out_jump_reg(out_jump_reg), .out_link(out_link), .out_illegal(out_illegal),
        .stall_cnt(stall_cnt)
    );

    exp_t obs;
    always_comb begin
        obs            = '0;
        obs.vld        = out_valid;
        obs.pc         = out_pc;
        obs.rs         = out_rs;
        obs.rt         = out_rt;
        obs.dest       = out_dest;
        obs.shamt      = out_shamt;
        obs.imm        = out_imm;
        obs.alu        = out_alu_ctrl;
        obs.alu_src    = out_alu_src;
        obs.reg_write  = out_reg_write;
        obs.mem_read   = out_mem_read;
        obs.mem_write  = out_mem_write;
        obs.mem_to_reg = out_mem_to_reg;
        obs.br         = out_branch_type;
        obs.jump       = out_jump;
        obs.jump_reg   = out_jump_reg;
        obs.link       = out_link;
        obs.illegal    = out_illegal;
    end

    // Instruction-set rules written as lookup tables over opcode / funct.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        e = '0;
        e.vld = 1'b1;
        e.pc = pc;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.shamt = ins[10:6];
        if (op >= 'h0C && op <= 'h0F) e.imm = {16'h0000, ins[15:0]};
        else                          e.imm = {{16{ins[15]}}, ins[15:0]};
        if (op == 0) begin
            case (fn)
                'h20: e.alu = 1;  'h21: e.alu = 2;  'h22: e.alu = 3;  'h23: e.alu = 4;
                'h24: e.alu = 5;  'h25: e.alu = 6;  'h26: e.alu = 7;  'h2A: e.alu = 8;
                'h00: e.alu = 9;  'h02: e.alu = 10; 'h03: e.alu = 11;
                default: e.alu = 0;
            endcase
            if (e.alu != 0) begin
                e.dest = ins[15:11];
                e.reg_write = 1'b1;
            end else if (fn == 'h08) e.jump_reg = 1'b1;
            else e.illegal = 1'b1;
        end else if (op inside {'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F}) begin
            case (op)
                'h08: e.alu = 1; 'h09: e.alu = 2; 'h0A: e.alu = 8; 'h0C: e.alu = 5;
                'h0D: e.alu = 6; 'h0E: e.alu = 7; default: e.alu = 12;
            endcase
            e.alu_src = 1'b1; e.dest = ins[20:16]; e.reg_write = 1'b1;
        end else if (op == 'h23) begin
            e.alu = 1; e.alu_src = 1'b1; e.dest = ins[20:16];
            e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
        end else if (op == 'h2B) begin
            e.alu = 1; e.alu_src = 1'b1; e.mem_write = 1'b1;
        end else if (op >= 'h04 && op <= 'h07) begin
            e.alu = 3; e.br = 4'(op - 'h04 + 1);
        end else if (op >= 'h14 && op <= 'h17) begin
            e.alu = 3; e.br = 4'(op - 'h14 + 5);
        end else if (op == 'h02) e.jump = 1'b1;
        else if (op == 'h03) begin
            e.jump = 1'b1; e.link = 1'b1; e.reg_write = 1'b1; e.dest = 5'd31;
        end else e.illegal = 1'b1;
        return e;
    endfunction

    function automatic bit model_uses_rt(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        return (op == 0) || (op == 'h2B) || (op >= 4 && op <= 7) || (op >= 'h14 && op <= 'h17);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs !== exp_t'(0) || stall_cnt !== 2'd0) begin
            fails++; $display("FAIL reset_state got %h stall %0d required 0", obs, stall_cnt);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h100;
        cyc();
        in_instr = 32'h3404FFFF; in_pc = 32'h104;
        tests++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== 5'd1 || out_dest !== 5'd3 ||
            out_reg_write !== 1'b1 || out_pc !== 32'h100) begin
            fails++; $display("FAIL b2b_add got v%b alu %0d dest %0d pc %h required v1 alu 1 dest 3 pc 100",
                              out_valid, out_alu_ctrl, out_dest, out_pc);
        end
        cyc();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== 5'd6 || out_imm !== 32'h0000FFFF ||
            out_dest !== 5'd4 || out_alu_src !== 1'b1) begin
            fails++; $display("FAIL b2b_ori got v%b alu %0d imm %h dest %0d required v1 alu 6 imm 0000ffff dest 4",
                              out_valid, out_alu_ctrl, out_imm, out_dest);
        end
        cyc();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got v%b required 0", out_valid);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd5;
        in_valid = 1'b1; in_instr = 32'h00A23020; in_pc = 32'h200;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL hazard_ready got %b required 0", in_ready);
        end
        cyc();
        tests++;
        if (out_valid !== 1'b0 || stall_cnt !== 2'd1) begin
            fails++; $display("FAIL hazard_bubble got v%b stall %0d required v0 stall 1", out_valid, stall_cnt);
        end
        ex_mem_read = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL hazard_release_ready got %b required 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_dest !== 5'd6 || out_pc !== 32'h200 || stall_cnt !== 2'd1) begin
            fails++; $display("FAIL hazard_issue got v%b dest %0d pc %h stall %0d required v1 dest 6 pc 200 stall 1",
                              out_valid, out_dest, out_pc, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_t held;
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1000FFFC; in_pc = 32'h300;
        cyc();
        held = obs;
        tests++;
        if (out_valid !== 1'b1 || out_branch_type !== 4'd1 || out_imm !== 32'hFFFFFFFC || out_alu_ctrl !== 5'd3) begin
            fails++; $display("FAIL beq_packet got v%b br %0d imm %h alu %0d required v1 br 1 imm fffffffc alu 3",
                              out_valid, out_branch_type, out_imm, out_alu_ctrl);
        end
        in_instr = 32'h00221820; in_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_ready cycle %0d got %b required 0", i, in_ready);
            end
            cyc();
            tests++;
            if (obs !== held) begin
                fails++; $display("FAIL stall_stable cycle %0d got %h required %h", i, obs, held);
            end
        end
        out_ready = 1'b1; in_valid = 1'b0;
        cyc();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_drain got v%b required 0", out_valid);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h400;
        cyc();
        flush = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        in_instr = 32'h00A23020; in_pc = 32'h404;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_ready got %b required 1", in_ready);
        end
        cyc();
        flush = 1'b0; ex_mem_read = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || stall_cnt !== 2'd0) begin
            fails++; $display("FAIL flush_squash got v%b stall %0d required v0 stall 0", out_valid, stall_cnt);
        end
        cyc();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_dropped got v%b required 0", out_valid);
        end
    endtask

    task automatic test_jr_illegal();
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h03E00008; in_pc = 32'h500;
        cyc();
        in_instr = 32'hFC000000; in_pc = 32'h504;
        tests++;
        if (out_valid !== 1'b1 || out_jump_reg !== 1'b1 || out_reg_write !== 1'b0 || out_rs !== 5'd31) begin
            fails++; $display("FAIL jr got v%b jr %b rw %b rs %0d required v1 jr 1 rw 0 rs 31",
                              out_valid, out_jump_reg, out_reg_write, out_rs);
        end
        cyc();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_ctrl !== 5'd0) begin
            fails++; $display("FAIL illegal got v%b ill %b rw %b alu %0d required v1 ill 1 rw 0 alu 0",
                              out_valid, out_illegal, out_reg_write, out_alu_ctrl);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        do_reset();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd1;
        in_valid = 1'b1; in_instr = 32'h00221820;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            want = (i > 3) ? 2'd3 : 2'(i);
            tests++;
            if (stall_cnt !== want || out_valid !== 1'b0) begin
                fails++; $display("FAIL stall_sat cycle %0d got %0d v%b required %0d v0", i, stall_cnt, out_valid, want);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd2; in_valid = 1'b1; in_instr = 32'h00221820;
        cyc();
        ex_mem_read = 1'b0; in_instr = 32'h8C250010; in_pc = 32'h600;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== exp_t'(0) || stall_cnt !== 2'd0) begin
            fails++; $display("FAIL async_reset got %h stall %0d required 0", obs, stall_cnt);
        end
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_random();
        exp_t       m_out;
        logic [1:0] m_stall;
        bit         m_adv, m_hz, m_rdy;
        logic [31:0] ins;
        int         ops[24] = '{0, 0, 0, 'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B,
                                4, 5, 6, 7, 'h14, 'h15, 'h16, 'h17, 2, 3, 'h3F, 1};
        int         fns[14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h2A, 0, 2, 3, 8, 'h3F, 'h11};
        int         op;
        do_reset();
        m_out = '0;
        m_stall = 2'd0;
        for (int c = 0; c < 400; c++) begin
            op = ops[$urandom_range(0, 23)];
            ins = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            if (op == 0) ins[5:0] = 6'(fns[$urandom_range(0, 13)]);
            in_instr    = ins;
            in_pc       = $urandom;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rt       = 5'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 15) == 0);
            m_adv = !m_out.vld || out_ready;
            m_hz  = in_valid && ex_mem_read && ex_rt != 0 &&
                    (ex_rt == ins[25:21] || (model_uses_rt(ins) && ex_rt == ins[20:16]));
            m_rdy = flush || (m_adv && !m_hz);
            #1;
            tests++;
            if (in_ready !== m_rdy) begin
                fails++; $display("FAIL rand_ready cycle %0d got %b required %b", c, in_ready, m_rdy);
            end
            if (flush) m_out.vld = 1'b0;
            else if (m_adv) begin
                if (m_hz) begin
                    m_out.vld = 1'b0;
                    if (m_stall != 2'd3) m_stall = m_stall + 2'd1;
                end else if (in_valid) m_out = model_decode(ins, in_pc);
                else m_out.vld = 1'b0;
            end
            cyc();
            tests++;
            if (out_valid !== m_out.vld || stall_cnt !== m_stall || (m_out.vld && obs !== m_out)) begin
                fails++; $display("FAIL rand_packet cycle %0d got %h stall %0d required %h stall %0d",
                                  c, obs, stall_cnt, m_out, m_stall);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush_hazard();
        test_jr_illegal();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
